// File: rtl/lms_pkg.sv
// Shared types and constants for the lms sample feeder.
// Holds the pair struct, default widths and a saturating increment.
package lms_pkg;

    localparam int LMS_W      = 16;
    localparam int LMS_PERIOD = 8;
    localparam int LMS_UCNT_W = 16;

    typedef struct packed {
        logic signed [LMS_W-1:0] x;
        logic signed [LMS_W-1:0] d;
    } lms_pair_t;

    function automatic logic [LMS_UCNT_W-1:0] sat_inc(
        input logic [LMS_UCNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lms_pair_fifo.sv
// Synchronous FIFO of {x,d} pairs with extra-bit full/empty pointers.
// Ports: i_push/i_wdata, i_pop/o_rdata (show-ahead), i_flush, o_full, o_empty, o_level.
module lms_pair_fifo
    import lms_pkg::*;
#(
    parameter type T     = lms_pair_t,
    parameter int  DEPTH = 16,
    parameter int  AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_push,
    input  T            i_wdata,
    input  logic        i_pop,
    output T            o_rdata,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_level
);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    T            r_mem [DEPTH];
    logic        w_wr;
    logic        w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign w_wr    = i_push && !o_full && !i_flush;
    assign w_rd    = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/lms_sample_feeder.sv
// Paces buffered {x,d} pairs onto the lms filter, one per PERIOD clocks,
// and counts empty-FIFO (underrun) periods.
// Ports: clk, rst_n (async, low), run, s_valid/s_ready/s_x/s_d (source),
//        xin/din/lms_en (to lms), tick, level, underrun_cnt, clr.
// Option: define LMS_FEEDER_PRIME_EN to hold pacing until the FIFO is half
//         full after reset, clr or a run rise.
module lms_sample_feeder
    import lms_pkg::*;
#(
    parameter int W      = LMS_W,
    parameter int PERIOD = LMS_PERIOD,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [W-1:0]          s_x,
    input  logic [W-1:0]          s_d,
    output logic [W-1:0]          xin,
    output logic [W-1:0]          din,
    output logic                  lms_en,
    output logic                  tick,
    output logic [AW:0]           level,
    output logic [LMS_UCNT_W-1:0] underrun_cnt,
    input  logic                  clr
);

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] d;
    } pair_t;

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_empty;
    logic          w_pace;
    logic          w_issue;
    pair_t         w_head;
    pair_t         w_wdata;

    assign s_ready = !w_full;
    assign w_wdata = '{x: s_x, d: s_d};

`ifdef LMS_FEEDER_PRIME_EN
    logic r_primed;
    logic w_lvl_ok;

    assign w_lvl_ok = (level >= (AW + 1)'(DEPTH / 2));
    // Pacing is held until the FIFO has been half full once per run.
    assign w_pace   = run && !clr && (r_primed || w_lvl_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_primed <= 1'b0;
        else        r_primed <= run && !clr && (r_primed || w_lvl_ok);
    end
`else
    assign w_pace = run;
`endif

    assign w_issue = w_pace && (r_cnt == LAST) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_cnt <= '0;
        else if (!w_pace)        r_cnt <= '0;
        else if (r_cnt == LAST)  r_cnt <= '0;
        else                     r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xin    <= '0;
            din    <= '0;
            lms_en <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= w_issue;
            if (w_issue) begin
                // An empty FIFO issues zeros with en low so lms never adapts.
                xin    <= w_empty ? '0 : w_head.x;
                din    <= w_empty ? '0 : w_head.d;
                lms_en <= !w_empty;
            end else if (clr || !w_pace) begin
                lms_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 underrun_cnt <= '0;
        else if (clr)               underrun_cnt <= '0;
        else if (w_issue && w_empty) underrun_cnt <= sat_inc(underrun_cnt);
    end

    lms_pair_fifo #(
        .T     (pair_t),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (clr),
        .i_push  (s_valid),
        .i_wdata (w_wdata),
        .i_pop   (w_issue),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

endmodule

// File: tb/tb_lms_sample_feeder.sv
// Directed self-checking bench for lms_sample_feeder.
// Default build checks pacing/underrun/full/clr/reset; prime build checks priming.
module tb_lms_sample_feeder;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          s_valid = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  s_x = '0;
    logic [W-1:0]  s_d = '0;
    logic          s_ready;
    logic [W-1:0]  xin;
    logic [W-1:0]  din;
    logic          lms_en;
    logic          tick;
    logic [AW:0]   level;
    logic [15:0]   underrun_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lms_sample_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_x          (s_x),
        .s_d          (s_d),
        .xin          (xin),
        .din          (din),
        .lms_en       (lms_en),
        .tick         (tick),
        .level        (level),
        .underrun_cnt (underrun_cnt),
        .clr          (clr)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_chk++;
        if (xin !== 16'h0 || din !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data xin=%h din=%h want 0", xin, din);
        end
        n_chk++;
        if (lms_en !== 1'b0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl en=%b tick=%b want 0", lms_en, tick);
        end
        n_chk++;
        if (level !== 5'd0 || underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt level=%0d ucnt=%0d want 0", level, underrun_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
        n_chk++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", s_ready);
        end
    endtask

    task automatic test_pacing;
        int nt = 0;
        int t1 = 0;
        int t2 = 0;
        run = 1'b1;
        s_valid = 1'b1;
        s_x = 16'h0100;
        s_d = 16'h0200;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 1) begin
                s_x = 16'h0101;
                s_d = 16'h0201;
            end
            if (e == 2) s_valid = 1'b0;
            if (tick) begin
                nt++;
                if (nt == 1) t1 = e;
                else t2 = e;
            end
            if (e == 2) begin
                n_chk++;
                if (level !== 5'd2) begin
                    n_fail++;
                    $display("FAIL pace_level got %0d want 2", level);
                end
            end
            if (e == 8) begin
                n_chk++;
                if (xin !== 16'h0100 || din !== 16'h0200 || lms_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pace_first xin=%h din=%h en=%b want 0100 0200 1",
                             xin, din, lms_en);
                end
            end
            if (e == 16) begin
                n_chk++;
                if (xin !== 16'h0101 || din !== 16'h0201 || lms_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pace_second xin=%h din=%h en=%b want 0101 0201 1",
                             xin, din, lms_en);
                end
            end
        end
        n_chk++;
        if (nt !== 2 || t1 !== 8 || t2 !== 16) begin
            n_fail++;
            $display("FAIL pace_ticks n=%0d at %0d,%0d want 2 at 8,16", nt, t1, t2);
        end
    endtask

    task automatic test_underrun;
        int nt = 0;
        for (int e = 17; e <= 40; e++) begin
            step();
            if (tick) nt++;
            if (e == 24) begin
                n_chk++;
                if (xin !== 16'h0 || din !== 16'h0 || lms_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL under_data xin=%h din=%h en=%b want 0 0 0",
                             xin, din, lms_en);
                end
            end
            if (e == 25) begin
                n_chk++;
                if (tick !== 1'b0) begin
                    n_fail++;
                    $display("FAIL under_tickfall got %b want 0", tick);
                end
            end
        end
        n_chk++;
        if (nt !== 3 || underrun_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL under_count ticks=%0d ucnt=%0d want 3 3", nt, underrun_cnt);
        end
        run = 1'b0;
        step();
    endtask

    task automatic test_full;
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_x = 16'(16'h0010 + i);
            s_d = 16'(16'h0020 + i);
            step();
        end
        n_chk++;
        if (level !== 5'd16 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state level=%0d rdy=%b want 16 0", level, s_ready);
        end
        s_x = 16'hDEAD;
        s_d = 16'hBEEF;
        step();
        n_chk++;
        if (level !== 5'd16) begin
            n_fail++;
            $display("FAIL full_reject level=%0d want 16", level);
        end
        s_valid = 1'b0;
        run = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) begin
                n_chk++;
                if (level !== 5'd16 || s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_hold level=%0d rdy=%b want 16 0", level, s_ready);
                end
            end
            if (e == 8) begin
                n_chk++;
                if (level !== 5'd15 || s_ready !== 1'b1 || xin !== 16'h0010 ||
                    din !== 16'h0020) begin
                    n_fail++;
                    $display("FAIL full_pop level=%0d rdy=%b xin=%h din=%h want 15 1 0010 0020",
                             level, s_ready, xin, din);
                end
            end
        end
    endtask

    task automatic test_clr;
        run = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_chk++;
        if (level !== 5'd0 || underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_first level=%0d ucnt=%0d want 0 0", level, underrun_cnt);
        end
        run = 1'b1;
        repeat (16) step();
        run = 1'b0;
        n_chk++;
        if (underrun_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL clr_setup_ucnt got %0d want 2", underrun_cnt);
        end
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_x = 16'(16'h0A00 + i);
            s_d = 16'(16'h0B00 + i);
            step();
        end
        s_valid = 1'b0;
        run = 1'b1;
        repeat (8) step();
        n_chk++;
        if (level !== 5'd5 || lms_en !== 1'b1 || xin !== 16'h0A00) begin
            n_fail++;
            $display("FAIL clr_setup level=%0d en=%b xin=%h want 5 1 0a00",
                     level, lms_en, xin);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_chk++;
        if (level !== 5'd0 || underrun_cnt !== 16'd0 || lms_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_apply level=%0d ucnt=%0d en=%b want 0 0 0",
                     level, underrun_cnt, lms_en);
        end
        n_chk++;
        if (xin !== 16'h0A00 || din !== 16'h0B00) begin
            n_fail++;
            $display("FAIL clr_hold xin=%h din=%h want 0a00 0b00", xin, din);
        end
    endtask

    task automatic test_async_reset;
        int guard = 0;
        s_valid = 1'b1;
        s_x = 16'h7777;
        s_d = 16'h8888;
        repeat (2) step();
        s_valid = 1'b0;
        while (!tick && guard < 12) begin
            step();
            guard++;
        end
        n_chk++;
        if (tick !== 1'b1 || lms_en !== 1'b1 || xin !== 16'h7777) begin
            n_fail++;
            $display("FAIL ares_setup tick=%b en=%b xin=%h want 1 1 7777",
                     tick, lms_en, xin);
        end
        repeat (3) step();
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (xin !== 16'h0 || din !== 16'h0 || lms_en !== 1'b0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL ares_out xin=%h din=%h en=%b tick=%b want 0",
                     xin, din, lms_en, tick);
        end
        n_chk++;
        if (level !== 5'd0 || underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ares_cnt level=%0d ucnt=%0d want 0 0", level, underrun_cnt);
        end
        run = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_chk++;
        if (s_ready !== 1'b1 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL ares_release rdy=%b level=%0d want 1 0", s_ready, level);
        end
    endtask

    task automatic test_prime;
        int early_tick = 0;
        int hit = 0;
        run = 1'b1;
        for (int e = 0; e < 60; e++) begin
            s_valid = (e % 4 == 0);
            s_x = 16'(16'h0300 + e);
            s_d = 16'(16'h0400 + e);
            step();
            if (tick && level < 5'd7) early_tick++;
            if (tick) hit++;
            n_chk++;
            if (underrun_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL prime_ucnt step %0d got %0d want 0", e, underrun_cnt);
            end
        end
        s_valid = 1'b0;
        n_chk++;
        if (early_tick !== 0 || hit == 0) begin
            n_fail++;
            $display("FAIL prime_tick early=%0d total=%0d want 0 and >0", early_tick, hit);
        end
        run = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
`ifdef LMS_FEEDER_PRIME_EN
        test_prime();
`else
        test_pacing();
        test_underrun();
        test_full();
        test_clr();
        test_async_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish");
        $fatal(1);
    end

endmodule
